// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester RAM arbiter: FSM states, owner encoding
// and the captured request record.
package mem_arb_pkg;

    localparam int MEM_AW = 8;
    localparam int MEM_DW = 16;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        DONE,
        VRD,
        VCMP
    } state_t;

    typedef enum logic {
        OWN_E,
        OWN_D
    } owner_t;

    typedef struct packed {
        logic              we;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
    } slot_t;

endpackage

// File: rtl/mem_access_arb_req_slot.sv
// Single pending-request register: captures a request pulse when empty, or when
// its own ack is retiring the previous request in the same cycle.
module req_slot
    import mem_arb_pkg::*;
(
    input  logic  clk,
    input  logic  rstn,
    input  logic  load,
    input  logic  clr,
    input  slot_t din,
    output logic  full,
    output slot_t q
);

    logic take;

    assign take = load && (!full || clr);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full <= 1'b0;
        end else if (take) begin
            full <= 1'b1;
        end else if (clr) begin
            full <= 1'b0;
        end
    end

    // Payload only needs to be valid while full, so it carries no reset.
    always_ff @(posedge clk) begin
        if (take) begin
            q <= din;
        end
    end

endmodule

// File: rtl/mem_access_arb.sv
// Round-robin sharing of one single-port synchronous RAM between the edit
// controller (E) and the display scanner (D). Optional macro: WRITE_VERIFY_EN.
module mem_access_arb
    import mem_arb_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          e_req,
    input  logic          e_we,
    input  logic [AW-1:0] e_addr,
    input  logic [DW-1:0] e_wdata,
    output logic          e_ack,
    output logic [DW-1:0] e_rdata,
    output logic          e_busy,
    output logic          e_err,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    slot_t  e_din, d_din, e_q, d_q, sel;
    logic   e_full, d_full, e_elig, d_elig;
    state_t state, state_nx;
    owner_t owner, owner_nx, last_grant, last_nx, grant;

    logic          mem_en_nx, mem_we_nx;
    logic [AW-1:0] mem_addr_nx;
    logic [DW-1:0] mem_wdata_nx;
    logic          e_ack_nx, d_ack_nx;
    logic [DW-1:0] e_rdata_nx, d_rdata_nx;
`ifdef WRITE_VERIFY_EN
    logic          verr, verr_nx, e_err_nx;
`endif

    assign e_din = '{we: e_we, addr: e_addr, wdata: e_wdata};
    assign d_din = '{we: 1'b0, addr: d_addr, wdata: '0};

    req_slot u_e_slot (
        .clk  (clk),
        .rstn (rstn),
        .load (e_req),
        .clr  (e_ack),
        .din  (e_din),
        .full (e_full),
        .q    (e_q)
    );

    req_slot u_d_slot (
        .clk  (clk),
        .rstn (rstn),
        .load (d_req),
        .clr  (d_ack),
        .din  (d_din),
        .full (d_full),
        .q    (d_q)
    );

    assign e_busy = e_full;
    assign d_busy = d_full;

    // A slot whose ack is showing this cycle is still full but already served.
    assign e_elig = e_full && !e_ack;
    assign d_elig = d_full && !d_ack;

    always_comb begin
        state_nx     = state;
        owner_nx     = owner;
        last_nx      = last_grant;
        grant        = OWN_E;
        sel          = e_q;
        mem_en_nx    = mem_en;
        mem_we_nx    = mem_we;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        e_ack_nx     = 1'b0;
        d_ack_nx     = 1'b0;
        e_rdata_nx   = e_rdata;
        d_rdata_nx   = d_rdata;
`ifdef WRITE_VERIFY_EN
        verr_nx      = verr;
        e_err_nx     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (e_elig && d_elig) begin
                    grant = (last_grant == OWN_E) ? OWN_D : OWN_E;
                end else if (d_elig) begin
                    grant = OWN_D;
                end
                sel = (grant == OWN_E) ? e_q : d_q;
                if (e_elig || d_elig) begin
                    mem_en_nx    = 1'b1;
                    mem_we_nx    = sel.we;
                    mem_addr_nx  = sel.addr;
                    mem_wdata_nx = sel.wdata;
                    owner_nx     = grant;
                    state_nx     = ACCESS;
                end
            end
            ACCESS: begin
                mem_en_nx = 1'b0;
                mem_we_nx = 1'b0;
                state_nx  = DONE;
`ifdef WRITE_VERIFY_EN
                // Only E writes, so a write here always gets a read-back.
                if (mem_we) begin
                    mem_en_nx = 1'b1;
                    state_nx  = VRD;
                end
`endif
            end
`ifdef WRITE_VERIFY_EN
            VRD: begin
                mem_en_nx = 1'b0;
                state_nx  = VCMP;
            end
            VCMP: begin
                verr_nx  = (mem_rdata != e_q.wdata);
                state_nx = DONE;
            end
`endif
            DONE: begin
                state_nx = IDLE;
                last_nx  = owner;
                if (owner == OWN_E) begin
                    e_ack_nx = 1'b1;
                    if (!e_q.we) begin
                        e_rdata_nx = mem_rdata;
                    end
`ifdef WRITE_VERIFY_EN
                    e_err_nx = e_q.we && verr;
`endif
                end else begin
                    d_ack_nx   = 1'b1;
                    d_rdata_nx = mem_rdata;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            owner      <= OWN_E;
            last_grant <= OWN_D;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            e_ack      <= 1'b0;
            d_ack      <= 1'b0;
            e_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_grant <= last_nx;
            mem_en     <= mem_en_nx;
            mem_we     <= mem_we_nx;
            mem_addr   <= mem_addr_nx;
            mem_wdata  <= mem_wdata_nx;
            e_ack      <= e_ack_nx;
            d_ack      <= d_ack_nx;
            e_rdata    <= e_rdata_nx;
            d_rdata    <= d_rdata_nx;
        end
    end

`ifdef WRITE_VERIFY_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            verr  <= 1'b0;
            e_err <= 1'b0;
        end else begin
            verr  <= verr_nx;
            e_err <= e_err_nx;
        end
    end
`else
    assign e_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_arb.sv
// Self-checking bench for mem_access_arb: RAM model plus a transaction-level
// reference (ordered memory updates, round-robin winner, per-access latency).
module tb_mem_access_arb;

    localparam int AW = 8;
    localparam int DW = 16;
`ifdef WRITE_VERIFY_EN
    localparam int WLAT = 6;
`else
    localparam int WLAT = 4;
`endif
    localparam int RLAT = 4;

    logic          clk;
    logic          rstn;
    logic          e_req, e_we, e_ack, e_busy, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;
    logic          d_req, d_ack, d_busy;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    mem_access_arb #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .e_req     (e_req),
        .e_we      (e_we),
        .e_addr    (e_addr),
        .e_wdata   (e_wdata),
        .e_ack     (e_ack),
        .e_rdata   (e_rdata),
        .e_busy    (e_busy),
        .e_err     (e_err),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_busy    (d_busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model; corrupt flips bit 0 of read data.
    logic [DW-1:0] ram [0:255];
    logic          corrupt;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr] ^ {{(DW-1){1'b0}}, corrupt};
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:255];
    int            lg;            // last grant: 0 = E, 1 = D
    logic [DW-1:0] m_e_rdata, m_d_rdata;

    int n_cmp, n_bad;

    logic          log_en [0:15];
    logic          log_we [0:15];
    logic [AW-1:0] log_addr [0:15];
    logic [DW-1:0] log_wd [0:15];

    function automatic int lat(input logic we);
        return we ? WLAT : RLAT;
    endfunction

    function automatic logic [15:0] bmask(input int l);
        return ((16'd1 << (l + 1)) - 16'd1) & ~16'd1;
    endfunction

    task automatic m_e(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input int idle, output int cyc);
        cyc = idle + lat(we) - 1;
        if (we) ref_mem[a] = wd;
        else    m_e_rdata = ref_mem[a];
        lg = 0;
    endtask

    task automatic m_d(input logic [AW-1:0] a, input int idle, output int cyc);
        cyc = idle + RLAT - 1;
        m_d_rdata = ref_mem[a];
        lg = 1;
    endtask

    // Predicted ack cycles (cycle 0 = request cycle) and resulting read data.
    task automatic predict(input bit do_e, input logic we, input logic [AW-1:0] ea,
                           input logic [DW-1:0] ewd, input bit do_d, input logic [AW-1:0] da,
                           output int ec, output int dc,
                           output logic [DW-1:0] erd, output logic [DW-1:0] drd);
        ec = -1;
        dc = -1;
        if (do_e && do_d) begin
            if (lg == 1) begin
                m_e(we, ea, ewd, 1, ec);
                m_d(da, ec, dc);
            end else begin
                m_d(da, 1, dc);
                m_e(we, ea, ewd, dc, ec);
            end
        end else if (do_e) begin
            m_e(we, ea, ewd, 1, ec);
        end else if (do_d) begin
            m_d(da, 1, dc);
        end
        erd = m_e_rdata;
        drd = m_d_rdata;
    endtask

    // Issue one or two request pulses in cycle 0 and observe a fixed window.
    task automatic run_txn(input bit do_e, input logic we, input logic [AW-1:0] ea,
                           input logic [DW-1:0] ewd, input bit do_d, input logic [AW-1:0] da,
                           output int e_cyc, output int e_n, output logic [DW-1:0] e_rd,
                           output logic e_er, output int d_cyc, output int d_n,
                           output logic [DW-1:0] d_rd, output logic [15:0] e_bm,
                           output logic [15:0] d_bm);
        @(posedge clk); #1;
        e_req = do_e; e_we = we; e_addr = ea; e_wdata = ewd;
        d_req = do_d; d_addr = da;
        e_cyc = -1; e_n = 0; e_rd = '0; e_er = 1'b0;
        d_cyc = -1; d_n = 0; d_rd = '0;
        e_bm = '0; d_bm = '0;
        log_en[0] = 1'b0; log_we[0] = 1'b0; log_addr[0] = '0; log_wd[0] = '0;
        for (int k = 1; k < 16; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                e_req = 1'b0;
                d_req = 1'b0;
            end
            @(negedge clk);
            e_bm[k] = e_busy;
            d_bm[k] = d_busy;
            log_en[k] = mem_en; log_we[k] = mem_we;
            log_addr[k] = mem_addr; log_wd[k] = mem_wdata;
            if (e_ack) begin
                e_n++;
                if (e_cyc < 0) begin
                    e_cyc = k; e_rd = e_rdata; e_er = e_err;
                end
            end
            if (d_ack) begin
                d_n++;
                if (d_cyc < 0) begin
                    d_cyc = k; d_rd = d_rdata;
                end
            end
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0; e_req = 1'b0; d_req = 1'b0; corrupt = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        lg = 1; m_e_rdata = '0; m_d_rdata = '0;
    endtask

    task automatic test_reset();
        logic [6:0]  ctl;
        logic [63:0] dat;
        rstn = 1'b0; e_req = 1'b0; d_req = 1'b0; e_we = 1'b0;
        e_addr = '0; e_wdata = '0; d_addr = '0; corrupt = 1'b0;
        #12;
        ctl = {e_ack, d_ack, e_busy, d_busy, e_err, mem_en, mem_we};
        dat = {mem_addr, mem_wdata, e_rdata, d_rdata, 8'h00};
        n_cmp++;
        if (ctl !== 7'b0) begin
            n_bad++; $display("FAIL reset_ctl: got %b want 0000000", ctl);
        end
        n_cmp++;
        if (dat !== 64'h0) begin
            n_bad++; $display("FAIL reset_data: got %h want 0", dat);
        end
        do_reset();
    endtask

    task automatic test_write_read();
        int ec, dc, en, dn, pec, pdc;
        logic [DW-1:0] erd, drd, perd, pdrd;
        logic er;
        logic [15:0] ebm, dbm;
        do_reset();
        predict(1, 1'b1, 8'h05, 16'hBEEF, 0, 8'h00, pec, pdc, perd, pdrd);
        run_txn(1, 1'b1, 8'h05, 16'hBEEF, 0, 8'h00, ec, en, erd, er, dc, dn, drd, ebm, dbm);
        n_cmp++;
        if (ec !== pec || en !== 1) begin
            n_bad++; $display("FAIL wr_ack: cycle %0d count %0d, want cycle %0d count 1", ec, en, pec);
        end
        n_cmp++;
        if ({log_en[2], log_we[2], log_addr[2], log_wd[2]} !== {1'b1, 1'b1, 8'h05, 16'hBEEF}) begin
            n_bad++; $display("FAIL wr_mem_c2: en %b we %b addr %h wd %h, want 1 1 05 beef",
                              log_en[2], log_we[2], log_addr[2], log_wd[2]);
        end
        n_cmp++;
        if (ebm !== bmask(WLAT)) begin
            n_bad++; $display("FAIL wr_busy: got %b want %b", ebm, bmask(WLAT));
        end
        n_cmp++;
        if (er !== 1'b0 || dn !== 0 || dbm !== 16'h0) begin
            n_bad++; $display("FAIL wr_side: err %b d_acks %0d d_busy %b, want 0 0 0", er, dn, dbm);
        end
        predict(1, 1'b0, 8'h05, 16'h0000, 0, 8'h00, pec, pdc, perd, pdrd);
        run_txn(1, 1'b0, 8'h05, 16'h0000, 0, 8'h00, ec, en, erd, er, dc, dn, drd, ebm, dbm);
        n_cmp++;
        if (ec !== RLAT || erd !== 16'hBEEF || erd !== perd) begin
            n_bad++; $display("FAIL rd_back: cycle %0d data %h, want cycle %0d data beef", ec, erd, RLAT);
        end
        n_cmp++;
        if (dn !== 0 || d_rdata !== pdrd) begin
            n_bad++; $display("FAIL rd_d_untouched: d_acks %0d d_rdata %h, want 0 %h", dn, d_rdata, pdrd);
        end
    endtask

    task automatic test_contention();
        int ec, dc, en, dn, pec, pdc;
        logic [DW-1:0] erd, drd, perd, pdrd;
        logic er;
        logic [15:0] ebm, dbm;
        do_reset();
        predict(1, 1'b1, 8'h10, 16'h1234, 1, 8'h10, pec, pdc, perd, pdrd);
        run_txn(1, 1'b1, 8'h10, 16'h1234, 1, 8'h10, ec, en, erd, er, dc, dn, drd, ebm, dbm);
        n_cmp++;
        if (ec !== WLAT || dc !== ec + 3 || en !== 1 || dn !== 1) begin
            n_bad++; $display("FAIL pair1_order: e_ack %0d d_ack %0d (counts %0d %0d), want %0d %0d",
                              ec, dc, en, dn, WLAT, WLAT + 3);
        end
        n_cmp++;
        if (drd !== 16'h1234 || drd !== pdrd) begin
            n_bad++; $display("FAIL pair1_drd: got %h want 1234", drd);
        end
        // A lone E access leaves last grant at E, so the next tie goes to D.
        predict(1, 1'b0, 8'h10, 16'h0000, 0, 8'h00, pec, pdc, perd, pdrd);
        run_txn(1, 1'b0, 8'h10, 16'h0000, 0, 8'h00, ec, en, erd, er, dc, dn, drd, ebm, dbm);
        n_cmp++;
        if (erd !== perd || ec !== pec) begin
            n_bad++; $display("FAIL mid_read: data %h cycle %0d want %h %0d", erd, ec, perd, pec);
        end
        predict(1, 1'b1, 8'h10, 16'h5678, 1, 8'h10, pec, pdc, perd, pdrd);
        run_txn(1, 1'b1, 8'h10, 16'h5678, 1, 8'h10, ec, en, erd, er, dc, dn, drd, ebm, dbm);
        n_cmp++;
        if (dc !== RLAT || ec !== RLAT + WLAT - 1 || ec !== pec || dc !== pdc) begin
            n_bad++; $display("FAIL pair2_order: e_ack %0d d_ack %0d, want %0d %0d",
                              ec, dc, RLAT + WLAT - 1, RLAT);
        end
        n_cmp++;
        if (drd !== 16'h1234) begin
            n_bad++; $display("FAIL pair2_drd: got %h want 1234", drd);
        end
    endtask

    task automatic test_reset_mid_access();
        int ec, dc, en, dn, pec, pdc, acks;
        logic [DW-1:0] erd, drd, perd, pdrd;
        logic er;
        logic [15:0] ebm, dbm;
        do_reset();
        @(posedge clk); #1;
        e_req = 1'b1; e_we = 1'b1; e_addr = 8'h22; e_wdata = 16'hA5A5;
        @(posedge clk); #1;
        e_req = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (mem_en !== 1'b1) begin
            n_bad++; $display("FAIL abort_pre: mem_en %b want 1", mem_en);
        end
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({mem_en, e_busy, e_ack} !== 3'b000) begin
            n_bad++; $display("FAIL abort_async: en/busy/ack %b want 000", {mem_en, e_busy, e_ack});
        end
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (e_ack || d_ack) acks++;
        end
        n_cmp++;
        if (acks !== 0) begin
            n_bad++; $display("FAIL abort_noack: saw %0d acks want 0", acks);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        lg = 1; m_e_rdata = '0; m_d_rdata = '0;
        predict(1, 1'b0, 8'h22, 16'h0000, 0, 8'h00, pec, pdc, perd, pdrd);
        run_txn(1, 1'b0, 8'h22, 16'h0000, 0, 8'h00, ec, en, erd, er, dc, dn, drd, ebm, dbm);
        n_cmp++;
        if (ec !== RLAT || erd !== perd) begin
            n_bad++; $display("FAIL abort_nowrite: cycle %0d data %h want %0d %h", ec, erd, RLAT, perd);
        end
        predict(1, 1'b1, 8'h22, 16'h3C3C, 0, 8'h00, pec, pdc, perd, pdrd);
        run_txn(1, 1'b1, 8'h22, 16'h3C3C, 0, 8'h00, ec, en, erd, er, dc, dn, drd, ebm, dbm);
        n_cmp++;
        if (ec !== WLAT || en !== 1 || ebm !== bmask(WLAT)) begin
            n_bad++; $display("FAIL abort_recover: cycle %0d count %0d busy %b want %0d 1 %b",
                              ec, en, ebm, WLAT, bmask(WLAT));
        end
    endtask

    task automatic test_write_verify();
        int ec, dc, en, dn, pec, pdc;
        logic [DW-1:0] erd, drd, perd, pdrd;
        logic er, exp_er;
        logic [15:0] ebm, dbm;
`ifdef WRITE_VERIFY_EN
        exp_er = 1'b1;
`else
        exp_er = 1'b0;
`endif
        corrupt = 1'b1;
        predict(1, 1'b1, 8'h30, 16'h00FF, 0, 8'h00, pec, pdc, perd, pdrd);
        run_txn(1, 1'b1, 8'h30, 16'h00FF, 0, 8'h00, ec, en, erd, er, dc, dn, drd, ebm, dbm);
        corrupt = 1'b0;
        n_cmp++;
        if (ec !== WLAT || er !== exp_er || erd !== perd) begin
            n_bad++; $display("FAIL verify_bad: cycle %0d err %b rdata %h want %0d %b %h",
                              ec, er, erd, WLAT, exp_er, perd);
        end
        predict(1, 1'b1, 8'h31, 16'h00FF, 0, 8'h00, pec, pdc, perd, pdrd);
        run_txn(1, 1'b1, 8'h31, 16'h00FF, 0, 8'h00, ec, en, erd, er, dc, dn, drd, ebm, dbm);
        n_cmp++;
        if (ec !== WLAT || er !== 1'b0) begin
            n_bad++; $display("FAIL verify_clean: cycle %0d err %b want %0d 0", ec, er, WLAT);
        end
    endtask

    task automatic test_random();
        int ec, dc, en, dn, pec, pdc, op;
        logic [DW-1:0] erd, drd, perd, pdrd, wd;
        logic er, we;
        logic [AW-1:0] ea, da;
        logic [15:0] ebm, dbm;
        bit do_e, do_d;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 3);
            ea = 8'($urandom_range(0, 7));
            da = 8'($urandom_range(0, 7));
            wd = 16'($urandom);
            we = (op == 0) || (op == 3 && $urandom_range(0, 1) == 1);
            do_e = (op != 2);
            do_d = (op >= 2);
            predict(do_e, we, ea, wd, do_d, da, pec, pdc, perd, pdrd);
            run_txn(do_e, we, ea, wd, do_d, da, ec, en, erd, er, dc, dn, drd, ebm, dbm);
            n_cmp++;
            if (en !== (do_e ? 1 : 0) || dn !== (do_d ? 1 : 0)) begin
                n_bad++; $display("FAIL rnd%0d_counts: e %0d d %0d want %0d %0d",
                                  i, en, dn, do_e, do_d);
            end
            if (do_e) begin
                n_cmp++;
                if (ec !== pec || erd !== perd || er !== 1'b0) begin
                    n_bad++; $display("FAIL rnd%0d_e: cycle %0d data %h err %b want %0d %h 0",
                                      i, ec, erd, er, pec, perd);
                end
            end
            if (do_d) begin
                n_cmp++;
                if (dc !== pdc || drd !== pdrd) begin
                    n_bad++; $display("FAIL rnd%0d_d: cycle %0d data %h want %0d %h",
                                      i, dc, drd, pdc, pdrd);
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 256; i++) begin
            ram[i] = '0;
            ref_mem[i] = '0;
        end
        test_reset();
        test_write_read();
        test_contention();
        test_reset_mid_access();
        test_write_verify();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_arb.md
Name: mem_access_arb

Overview:
- Sequences and shares one single-port synchronous RAM between two requesters.
- Requester E is the hex-keypad edit controller; it writes the digits it collects and reads back for prev/next.
- Requester D is the display/readback scanner.
- Per-requester busy feeds the edit controller's busy input; single-cycle request pulses are queued so no request is lost while the RAM is occupied.

Parameters:
- AW, 8, RAM address width
- DW, 16, RAM data width

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- e_req  in  1  E request pulse (one cycle)
- e_we  in  1  E write (1) / read (0), qualified by e_req
- e_addr  in  AW  E address, qualified by e_req
- e_wdata  in  DW  E write data, qualified by e_req
- e_ack  out  1  E completion pulse
- e_rdata  out  DW  E read data, valid with e_ack and held until the next E read
- e_busy  out  1  E request pending or in flight
- e_err  out  1  write-verify mismatch, pulses with e_ack
- d_req  in  1  D read request pulse
- d_addr  in  AW  D address, qualified by d_req
- d_ack  out  1  D completion pulse
- d_rdata  out  DW  D read data, valid with d_ack and held
- d_busy  out  1  D request pending or in flight
- mem_en  out  1  RAM enable (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_addr  out  AW  RAM address (registered)
- mem_wdata  out  DW  RAM write data (registered)
- mem_rdata  in  DW  RAM read data; valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset (asynchronous, rstn low): all outputs 0, both pending slots empty, state IDLE, last_grant=D. Any access in flight is abandoned with no ack.
- Request capture: a slot latches {we, addr, wdata} on the edge where req=1 and the slot is empty.
  - req=1 while the slot is full is dropped; the requester must not request while busy.
  - Exception: req=1 in the same cycle as the slot's own ack is accepted (slot refills).
- Busy: e_busy = E slot full; d_busy = D slot full. Busy covers capture through the ack cycle.
- States: IDLE, ACCESS, DONE.
  - IDLE: if any slot is full, grant one. On conflict grant the requester that is not last_grant (round-robin). Register mem_* from the granted slot with mem_en=1, set owner, go to ACCESS.
  - ACCESS: mem_en held for exactly this cycle. Next state is DONE; mem_en=0 on leaving.
  - DONE: for a read, capture mem_rdata into the owner's rdata. Pulse the owner's ack for one cycle, clear its slot, update last_grant, return to IDLE.
- Latency, uncontended: req in cycle 0, grant edge at end of cycle 1, ACCESS in cycle 2, ack high in cycle 4.
  - Throughput: one access per 3 cycles.
- Worst-case wait: one foreign access.
- D is read-only: d_req never writes, and there is no d_we.
- e_err is always 0 without the optional feature.

Optional Feature:
- Macro: WRITE_VERIFY_EN.
- Enabled: after an E write's ACCESS, add states VRD (mem_en=1, mem_we=0, same address) and VCMP (compare mem_rdata to the slot's wdata).
  - e_ack is delayed 2 cycles.
  - e_err=1 with e_ack on mismatch.
  - e_rdata is not updated.
  - D writes do not exist, so D is unaffected.
- Disabled: states absent, e_err tied 0.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ACCESS, DONE, VRD, VCMP}
  - owner encoding {OWN_E, OWN_D}
  - slot record type {we, addr, wdata}
- Sub-module: req_slot (capture register with full flag and clear), instantiated twice. D instance has we tied 0.

Test Plan:
- Reset then E write addr 0x05 data 0xBEEF (single req pulse), cycle 0:
  - mem_en=1, mem_we=1, addr 0x05 in cycle 2
  - e_ack in cycle 4
  - e_busy high cycles 1-4
- E read 0x05 after the write: e_rdata=0xBEEF with e_ack; d_* untouched.
- E and D requests in the same cycle (E write 0x10=0x1234, D read 0x10):
  - E granted first (last_grant=D after reset)
  - D ack 3 cycles after E ack
  - d_rdata=0x1234
- Repeat the simultaneous pair: D now wins (round-robin alternates).
- Assert rstn low during ACCESS:
  - mem_en drops immediately, no ack, busy=0
  - after release a new E request completes normally
- WRITE_VERIFY_EN build, RAM model corrupting bit 0:
  - E write 0x00FF gives e_ack at cycle 6 with e_err=1
  - with a clean RAM model, e_err=0
